// File: rtl/write_back_merge_unit.sv
// Write-back merge: late load returns and the in-order pipe channel share one register-file port.
// Optional forwarding lookup into the retire queue is compiled in when WB_FORWARD_EN is defined.
package write_back_merge_unit_pkg;
    typedef enum logic [1:0] {
        FROM_ALU    = 2'd0,
        FROM_MEMORY = 2'd1
    } reg_file_data_source;

    typedef logic reg_file_write_sig;
endpackage

module write_back_merge_unit
    import write_back_merge_unit_pkg::*;
#(
    parameter int unsigned WORD       = 32,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic                          pipe_valid_i,
    output logic                          pipe_ready_o,
    input  reg_file_data_source           pipe_src_i,
    input  reg_file_write_sig             pipe_write_en_i,
    input  logic [ADDR_WIDTH-1:0]         pipe_dest_addr_i,
    input  logic [WORD-1:0]               pipe_alu_result_i,
    input  logic [WORD-1:0]               pipe_mem_data_i,
    input  logic                          ld_valid_i,
    input  logic [ADDR_WIDTH-1:0]         ld_dest_addr_i,
    input  logic [WORD-1:0]               ld_data_i,
    input  logic [ADDR_WIDTH-1:0]         lookup_addr_i,
    output logic                          lookup_hit_o,
    output logic [WORD-1:0]               lookup_data_o,
    output reg_file_write_sig             reg_file_write_en_o,
    output logic [ADDR_WIDTH-1:0]         reg_dest_addr_o,
    output logic [WORD-1:0]               reg_data_o,
    output logic [$clog2(DEPTH):0]        pending_count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [CW-1:0]         count_q, count_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] ent_addr_q [DEPTH];
    logic [WORD-1:0]       ent_data_q [DEPTH];

    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [WORD-1:0]       wr_data_q, wr_data_d;

    logic                  pipe_fire;
    logic                  pipe_wr;
    logic [WORD-1:0]       pipe_data;
    logic                  queue_empty;
    logic                  push;
    logic                  pop;

    assign queue_empty  = (count_q == '0);
    assign pipe_ready_o = (count_q < CW'(DEPTH));
    assign pipe_fire    = pipe_valid_i & pipe_ready_o;
    assign pipe_wr      = pipe_fire & pipe_write_en_i;

    // Result select; unknown source encodings write zero.
    always_comb begin
        pipe_data = '0;
        case (pipe_src_i)
            FROM_ALU:    pipe_data = pipe_alu_result_i;
            FROM_MEMORY: pipe_data = pipe_mem_data_i;
            default:     pipe_data = '0;
        endcase
    end

    // Port arbitration: load return, then queue head, then pipe bypass.
    always_comb begin
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        pop       = 1'b0;
        push      = 1'b0;
        if (ld_valid_i) begin
            wr_en_d   = 1'b1;
            wr_addr_d = ld_dest_addr_i;
            wr_data_d = ld_data_i;
            push      = pipe_wr;
        end else if (!queue_empty) begin
            wr_en_d   = 1'b1;
            wr_addr_d = ent_addr_q[rd_ptr_q];
            wr_data_d = ent_data_q[rd_ptr_q];
            pop       = 1'b1;
            push      = pipe_wr;
        end else if (pipe_wr) begin
            wr_en_d   = 1'b1;
            wr_addr_d = pipe_dest_addr_i;
            wr_data_d = pipe_data;
        end
    end

    always_comb begin
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_q   <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            count_q   <= count_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Entry storage needs no reset: only slots below count are ever read.
    always_ff @(posedge clk_i) begin
        if (push) begin
            ent_addr_q[wr_ptr_q] <= pipe_dest_addr_i;
            ent_data_q[wr_ptr_q] <= pipe_data;
        end
    end

`ifdef WB_FORWARD_EN
    // Scan oldest to youngest so the last match wins.
    always_comb begin
        logic [PW-1:0] idx;
        lookup_hit_o  = 1'b0;
        lookup_data_o = '0;
        idx           = '0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            idx = rd_ptr_q + PW'(k);
            if ((CW'(k) < count_q) && (ent_addr_q[idx] == lookup_addr_i)) begin
                lookup_hit_o  = 1'b1;
                lookup_data_o = ent_data_q[idx];
            end
        end
    end
`else
    logic unused_lookup;
    assign unused_lookup = ^lookup_addr_i;
    assign lookup_hit_o  = 1'b0;
    assign lookup_data_o = '0;
`endif

    assign reg_file_write_en_o = wr_en_q;
    assign reg_dest_addr_o     = wr_addr_q;
    assign reg_data_o          = wr_data_q;
    assign pending_count_o     = count_q;

endmodule

// File: tb/tb_write_back_merge_unit.sv
// Bench for write_back_merge_unit: directed scenarios plus random traffic against a queue model.
// Lookup expectations follow WB_FORWARD_EN.
module tb_write_back_merge_unit;
    import write_back_merge_unit_pkg::*;

    localparam int unsigned WORD  = 32;
    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 4;

    logic                clk = 1'b0;
    logic                rst_n_i;
    logic                pipe_valid_i;
    logic                pipe_ready_o;
    reg_file_data_source pipe_src_i;
    reg_file_write_sig   pipe_write_en_i;
    logic [AW-1:0]       pipe_dest_addr_i;
    logic [WORD-1:0]     pipe_alu_result_i;
    logic [WORD-1:0]     pipe_mem_data_i;
    logic                ld_valid_i;
    logic [AW-1:0]       ld_dest_addr_i;
    logic [WORD-1:0]     ld_data_i;
    logic [AW-1:0]       lookup_addr_i;
    logic                lookup_hit_o;
    logic [WORD-1:0]     lookup_data_o;
    reg_file_write_sig   reg_file_write_en_o;
    logic [AW-1:0]       reg_dest_addr_o;
    logic [WORD-1:0]     reg_data_o;
    logic [$clog2(DEPTH):0] pending_count_o;

    write_back_merge_unit #(.WORD(WORD), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_n_i(rst_n_i),
        .pipe_valid_i(pipe_valid_i), .pipe_ready_o(pipe_ready_o),
        .pipe_src_i(pipe_src_i), .pipe_write_en_i(pipe_write_en_i),
        .pipe_dest_addr_i(pipe_dest_addr_i), .pipe_alu_result_i(pipe_alu_result_i),
        .pipe_mem_data_i(pipe_mem_data_i),
        .ld_valid_i(ld_valid_i), .ld_dest_addr_i(ld_dest_addr_i), .ld_data_i(ld_data_i),
        .lookup_addr_i(lookup_addr_i), .lookup_hit_o(lookup_hit_o), .lookup_data_o(lookup_data_o),
        .reg_file_write_en_o(reg_file_write_en_o), .reg_dest_addr_o(reg_dest_addr_o),
        .reg_data_o(reg_data_o), .pending_count_o(pending_count_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: a plain queue of pending pipe writes plus the last write seen.
    logic [AW-1:0]   mq_addr [$];
    logic [WORD-1:0] mq_data [$];
    logic            exp_we;
    logic [AW-1:0]   exp_addr;
    logic [WORD-1:0] exp_data;
    logic            exp_ready_seen;
    logic            dut_ready_seen;

    task automatic model_reset();
        mq_addr.delete();
        mq_data.delete();
        exp_we   = 1'b0;
        exp_addr = '0;
        exp_data = '0;
    endtask

    task automatic model_lookup(input logic [AW-1:0] a, output logic hit, output logic [WORD-1:0] d);
        hit = 1'b0;
        d   = '0;
        for (int i = mq_addr.size() - 1; i >= 0; i--) begin
            if (mq_addr[i] == a) begin
                hit = 1'b1;
                d   = mq_data[i];
                break;
            end
        end
`ifndef WB_FORWARD_EN
        hit = 1'b0;
        d   = '0;
`endif
    endtask

    // Drive one cycle of inputs, advance one edge, update the model; returns #1 after the edge.
    task automatic step(input logic pv, input logic [1:0] src, input logic we, input logic [AW-1:0] a,
                        input logic [WORD-1:0] alu, input logic [WORD-1:0] mem,
                        input logic ldv, input logic [AW-1:0] la, input logic [WORD-1:0] ld);
        logic [WORD-1:0] pd;
        logic fire;
        pipe_valid_i      = pv;
        pipe_src_i        = reg_file_data_source'(src);
        pipe_write_en_i   = we;
        pipe_dest_addr_i  = a;
        pipe_alu_result_i = alu;
        pipe_mem_data_i   = mem;
        ld_valid_i        = ldv;
        ld_dest_addr_i    = la;
        ld_data_i         = ld;
        #1;
        dut_ready_seen = pipe_ready_o;
        exp_ready_seen = (mq_addr.size() < DEPTH);
        @(posedge clk);
        pd   = (src == 2'd0) ? alu : (src == 2'd1) ? mem : '0;
        fire = pv && exp_ready_seen && we;
        exp_we = 1'b1;
        if (ldv) begin
            exp_addr = la;
            exp_data = ld;
            if (fire) begin mq_addr.push_back(a); mq_data.push_back(pd); end
        end else if (mq_addr.size() != 0) begin
            exp_addr = mq_addr.pop_front();
            exp_data = mq_data.pop_front();
            if (fire) begin mq_addr.push_back(a); mq_data.push_back(pd); end
        end else if (fire) begin
            exp_addr = a;
            exp_data = pd;
        end else begin
            exp_we = 1'b0;
        end
        #1;
    endtask

    task automatic idle();
        step(1'b0, 2'd0, 1'b0, '0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic test_reset();
        n_checks++; if (reg_file_write_en_o !== 1'b0) $display("FAIL reset_we: got %0b expected 0", reg_file_write_en_o); else n_pass++;
        n_checks++; if (reg_dest_addr_o !== '0) $display("FAIL reset_addr: got %0h expected 0", reg_dest_addr_o); else n_pass++;
        n_checks++; if (reg_data_o !== '0) $display("FAIL reset_data: got %0h expected 0", reg_data_o); else n_pass++;
        n_checks++; if (pending_count_o !== '0) $display("FAIL reset_count: got %0d expected 0", pending_count_o); else n_pass++;
        n_checks++; if (pipe_ready_o !== 1'b1) $display("FAIL reset_ready: got %0b expected 1", pipe_ready_o); else n_pass++;
        n_checks++; if (lookup_hit_o !== 1'b0) $display("FAIL reset_hit: got %0b expected 0", lookup_hit_o); else n_pass++;
    endtask

    task automatic test_bypass();
        step(1'b1, 2'd0, 1'b1, 4'd3, 32'h1234, 32'h0, 1'b0, '0, '0);
        n_checks++; if ({reg_file_write_en_o, reg_dest_addr_o, reg_data_o} !== {1'b1, 4'd3, 32'h1234})
            $display("FAIL bypass_write: got we=%0b a=%0d d=%0h expected we=1 a=3 d=1234", reg_file_write_en_o, reg_dest_addr_o, reg_data_o); else n_pass++;
        n_checks++; if (pending_count_o !== 3'd0) $display("FAIL bypass_count: got %0d expected 0", pending_count_o); else n_pass++;
        idle();
        n_checks++; if (reg_file_write_en_o !== 1'b0) $display("FAIL bypass_we_drop: got %0b expected 0", reg_file_write_en_o); else n_pass++;
        n_checks++; if (reg_data_o !== 32'h1234) $display("FAIL bypass_hold: got %0h expected 1234", reg_data_o); else n_pass++;
    endtask

    task automatic test_ld_collision();
        step(1'b1, 2'd1, 1'b1, 4'd5, 32'h0, 32'hCAFE, 1'b1, 4'd7, 32'hBEEF);
        n_checks++; if ({reg_file_write_en_o, reg_dest_addr_o, reg_data_o} !== {1'b1, 4'd7, 32'hBEEF})
            $display("FAIL coll_ld: got we=%0b a=%0d d=%0h expected we=1 a=7 d=beef", reg_file_write_en_o, reg_dest_addr_o, reg_data_o); else n_pass++;
        n_checks++; if (pending_count_o !== 3'd1) $display("FAIL coll_count1: got %0d expected 1", pending_count_o); else n_pass++;
        idle();
        n_checks++; if ({reg_file_write_en_o, reg_dest_addr_o, reg_data_o} !== {1'b1, 4'd5, 32'hCAFE})
            $display("FAIL coll_pipe: got we=%0b a=%0d d=%0h expected we=1 a=5 d=cafe", reg_file_write_en_o, reg_dest_addr_o, reg_data_o); else n_pass++;
        n_checks++; if (pending_count_o !== 3'd0) $display("FAIL coll_count0: got %0d expected 0", pending_count_o); else n_pass++;
        idle();
    endtask

    task automatic test_starve();
        for (int k = 0; k < 6; k++) begin
            step(1'b1, 2'd0, 1'b1, AW'(k + 1), 32'h100 + k, 32'h0, 1'b1, AW'(10 + k), 32'hA000 + k);
            n_checks++; if (dut_ready_seen !== (k < 4)) $display("FAIL starve_ready%0d: got %0b expected %0b", k, dut_ready_seen, k < 4); else n_pass++;
            n_checks++; if ({reg_dest_addr_o, reg_data_o} !== {AW'(10 + k), 32'hA000 + k})
                $display("FAIL starve_ld%0d: got a=%0d d=%0h expected a=%0d d=%0h", k, reg_dest_addr_o, reg_data_o, 10 + k, 32'hA000 + k); else n_pass++;
        end
        n_checks++; if (pending_count_o !== 3'd4) $display("FAIL starve_full: got %0d expected 4", pending_count_o); else n_pass++;
        for (int j = 0; j < 4; j++) begin
            idle();
            n_checks++; if ({reg_file_write_en_o, reg_dest_addr_o, reg_data_o} !== {1'b1, AW'(j + 1), 32'h100 + j})
                $display("FAIL starve_drain%0d: got we=%0b a=%0d d=%0h expected we=1 a=%0d d=%0h", j, reg_file_write_en_o, reg_dest_addr_o, reg_data_o, j + 1, 32'h100 + j); else n_pass++;
            if (j == 0) begin
                n_checks++; if (pipe_ready_o !== 1'b1) $display("FAIL starve_ready_back: got %0b expected 1", pipe_ready_o); else n_pass++;
            end
        end
        idle();
        n_checks++; if (reg_file_write_en_o !== 1'b0) $display("FAIL starve_end_we: got %0b expected 0", reg_file_write_en_o); else n_pass++;
    endtask

    task automatic test_nowrite_badsrc();
        step(1'b1, 2'd0, 1'b0, 4'd9, 32'h99, 32'h0, 1'b0, '0, '0);
        n_checks++; if (dut_ready_seen !== 1'b1) $display("FAIL nowr_ready: got %0b expected 1", dut_ready_seen); else n_pass++;
        n_checks++; if (reg_file_write_en_o !== 1'b0) $display("FAIL nowr_we: got %0b expected 0", reg_file_write_en_o); else n_pass++;
        n_checks++; if (pending_count_o !== 3'd0) $display("FAIL nowr_count: got %0d expected 0", pending_count_o); else n_pass++;
        step(1'b1, 2'd2, 1'b1, 4'd6, 32'h55, 32'h66, 1'b0, '0, '0);
        n_checks++; if ({reg_file_write_en_o, reg_dest_addr_o, reg_data_o} !== {1'b1, 4'd6, 32'h0})
            $display("FAIL badsrc: got we=%0b a=%0d d=%0h expected we=1 a=6 d=0", reg_file_write_en_o, reg_dest_addr_o, reg_data_o); else n_pass++;
        idle();
    endtask

    task automatic test_lookup();
        logic hit_e;
        logic [WORD-1:0] d_e;
        step(1'b1, 2'd0, 1'b1, 4'd2, 32'h11, 32'h0, 1'b1, 4'd1, 32'h77);
        step(1'b1, 2'd0, 1'b1, 4'd2, 32'h22, 32'h0, 1'b1, 4'd1, 32'h78);
        lookup_addr_i = 4'd2;
        #1;
`ifdef WB_FORWARD_EN
        hit_e = 1'b1; d_e = 32'h22;
`else
        hit_e = 1'b0; d_e = 32'h0;
`endif
        n_checks++; if ({lookup_hit_o, lookup_data_o} !== {hit_e, d_e})
            $display("FAIL lookup_r2: got hit=%0b d=%0h expected hit=%0b d=%0h", lookup_hit_o, lookup_data_o, hit_e, d_e); else n_pass++;
        lookup_addr_i = 4'd4;
        #1;
        n_checks++; if ({lookup_hit_o, lookup_data_o} !== {1'b0, 32'h0})
            $display("FAIL lookup_r4: got hit=%0b d=%0h expected hit=0 d=0", lookup_hit_o, lookup_data_o); else n_pass++;
        idle();
        idle();
        idle();
    endtask

    task automatic test_random();
        logic hit_e;
        logic [WORD-1:0] d_e;
        for (int c = 0; c < 400; c++) begin
            step(($urandom_range(0, 9) < 7), 2'($urandom_range(0, 2)), ($urandom_range(0, 7) != 0),
                 AW'($urandom), $urandom, $urandom, ($urandom_range(0, 3) == 0), AW'($urandom), $urandom);
            n_checks++; if (dut_ready_seen !== exp_ready_seen) $display("FAIL rnd_ready@%0d: got %0b expected %0b", c, dut_ready_seen, exp_ready_seen); else n_pass++;
            n_checks++; if ({reg_file_write_en_o, reg_dest_addr_o, reg_data_o} !== {exp_we, exp_addr, exp_data})
                $display("FAIL rnd_write@%0d: got we=%0b a=%0d d=%0h expected we=%0b a=%0d d=%0h", c,
                         reg_file_write_en_o, reg_dest_addr_o, reg_data_o, exp_we, exp_addr, exp_data); else n_pass++;
            n_checks++; if (pending_count_o !== ($clog2(DEPTH) + 1)'(mq_addr.size()))
                $display("FAIL rnd_count@%0d: got %0d expected %0d", c, pending_count_o, mq_addr.size()); else n_pass++;
            lookup_addr_i = AW'($urandom_range(0, 3));
            #1;
            model_lookup(lookup_addr_i, hit_e, d_e);
            n_checks++; if ({lookup_hit_o, lookup_data_o} !== {hit_e, d_e})
                $display("FAIL rnd_lookup@%0d: got hit=%0b d=%0h expected hit=%0b d=%0h", c, lookup_hit_o, lookup_data_o, hit_e, d_e); else n_pass++;
        end
        for (int j = 0; j < int'(DEPTH) + 2; j++) idle();
        n_checks++; if (pending_count_o !== '0) $display("FAIL rnd_drain: got %0d expected 0", pending_count_o); else n_pass++;
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 3; k++)
            step(1'b1, 2'd0, 1'b1, AW'(k + 2), 32'h300 + k, 32'h0, 1'b1, 4'd12, 32'hD00D);
        n_checks++; if (pending_count_o !== 3'd3) $display("FAIL arst_pre_count: got %0d expected 3", pending_count_o); else n_pass++;
        lookup_addr_i = 4'd2;
        #2;
        rst_n_i = 1'b0;
        #1;
        model_reset();
        n_checks++; if ({reg_file_write_en_o, reg_dest_addr_o, reg_data_o} !== {1'b0, 4'd0, 32'h0})
            $display("FAIL arst_out: got we=%0b a=%0d d=%0h expected all 0", reg_file_write_en_o, reg_dest_addr_o, reg_data_o); else n_pass++;
        n_checks++; if ({pending_count_o, pipe_ready_o, lookup_hit_o} !== {3'd0, 1'b1, 1'b0})
            $display("FAIL arst_state: got count=%0d ready=%0b hit=%0b expected 0 1 0", pending_count_o, pipe_ready_o, lookup_hit_o); else n_pass++;
        @(negedge clk);
        rst_n_i = 1'b1;
        for (int j = 0; j < 4; j++) begin
            idle();
            n_checks++; if (reg_file_write_en_o !== 1'b0) $display("FAIL arst_ghost%0d: got we=%0b expected 0", j, reg_file_write_en_o); else n_pass++;
        end
    endtask

    initial begin
        rst_n_i = 1'b0;
        pipe_valid_i = 1'b0; pipe_src_i = FROM_ALU; pipe_write_en_i = 1'b0;
        pipe_dest_addr_i = '0; pipe_alu_result_i = '0; pipe_mem_data_i = '0;
        ld_valid_i = 1'b0; ld_dest_addr_i = '0; ld_data_i = '0; lookup_addr_i = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n_i = 1'b1;
        #1;
        test_reset();
        test_bypass();
        test_ld_collision();
        test_starve();
        test_nowrite_badsrc();
        test_lookup();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/write_back_merge_unit.md
# write_back_merge_unit

Parametrised write-back stage that merges two result channels onto the single register-file write port. Channel 1 is the in-order pipe from the memory stage: ALU or memory data selected per instruction, with valid/ready flow control. Channel 2 is a late load-return path from the data-memory interface: always accepted, highest priority. Pipe results that lose arbitration wait in a DEPTH-entry in-order retire queue, and an optional lookup port forwards pending values to the decode stage.

## Interface
Parameters:
- WORD, 32, data width
- ADDR_WIDTH, 4, register address width
- DEPTH, 4, retire queue entries (power of two, ≥2)

Ports:
- clk_i  in  1  clock; all state updates on the rising edge
- rst_n_i  in  1  reset; asynchronous, active-low
- pipe_valid_i  in  1  pipe channel request valid
- pipe_ready_o  out  1  pipe channel can accept this cycle
- pipe_src_i  in  reg_file_data_source  FROM_ALU / FROM_MEMORY select
- pipe_write_en_i  in  reg_file_write_sig  instruction writes a register
- pipe_dest_addr_i  in  ADDR_WIDTH  destination register
- pipe_alu_result_i  in  WORD  ALU result
- pipe_mem_data_i  in  WORD  memory data
- ld_valid_i  in  1  load-return valid (no ready)
- ld_dest_addr_i  in  ADDR_WIDTH  load destination
- ld_data_i  in  WORD  load data
- lookup_addr_i  in  ADDR_WIDTH  forwarding query address
- lookup_hit_o  out  1  query matches a pending queue entry
- lookup_data_o  out  WORD  data of the youngest matching entry
- reg_file_write_en_o  out  reg_file_write_sig  register-file write strobe (registered)
- reg_dest_addr_o  out  ADDR_WIDTH  register-file address (registered)
- reg_data_o  out  WORD  register-file data (registered)
- pending_count_o  out  $clog2(DEPTH)+1  queue occupancy

## Operation
- Pipe handshake: a transfer occurs when pipe_valid_i & pipe_ready_o at the clock edge.
- pipe_ready_o = (count < DEPTH). It is computed from registered state only and has no combinational path from any input.
- Data select: FROM_ALU → pipe_alu_result_i; FROM_MEMORY → pipe_mem_data_i; any other encoding → 0.
- A transferred pipe request with pipe_write_en_i deasserted is consumed and discarded. It writes nothing and is not queued.
- Write-port arbitration, evaluated each cycle in priority order:
  - ld_valid_i → write the load return.
  - Else queue non-empty → write the queue head and pop it.
  - Else a transferring writing pipe request → write it directly (bypass; not queued).
  - Else no write; reg_file_write_en_o deasserts next cycle.
- A writing pipe transfer that does not win the port is pushed to the queue tail. Push and pop in the same cycle are both allowed; count is unchanged.
- The pipe channel retires strictly in order. No ordering is enforced between the load-return channel and the pipe channel; the issuing logic guarantees that no register has an outstanding load and a pending pipe write at once.
- Queue: circular buffer. Read/write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH; count is tracked separately.
- Lookup: combinational scan of valid queue entries. lookup_hit_o is asserted if any entry matches lookup_addr_i. lookup_data_o returns the data of the youngest match, and is 0 on a miss.
- Entries held in the output register do not participate in lookup.

## Timing
- Reset (rst_n_i low, asynchronous): reg_file_write_en_o deasserted, reg_dest_addr_o = 0, reg_data_o = 0, count = 0, pointers = 0, therefore pipe_ready_o = 1 and lookup_hit_o = 0.
- Reset asserted mid-operation discards all queued entries; no write completes for them.
- Latency:
  - bypass or load return: request at edge N, write visible on outputs during cycle N+1.
  - queued entry: written one cycle after it becomes head with ld_valid_i low.
- Output registers hold their values for exactly one cycle per write. With no write, reg_file_write_en_o is deasserted and address/data hold their last values.
- Full: count == DEPTH → pipe_ready_o low; a pop in that cycle raises ready on the following cycle, not combinationally.
- Continuous ld_valid_i starves the queue. Every pipe transfer is queued until the queue fills, after which ready stays low.

## Configuration
- WB_FORWARD_EN defined: the lookup port is functional as described.
- WB_FORWARD_EN undefined: the scan logic is not compiled; lookup_hit_o = 0 and lookup_data_o = 0 constantly, and lookup_addr_i is ignored. Write-back behaviour is identical in both builds.

## Test plan
- Reset then a single pipe request (FROM_ALU, write_en, addr 3, alu 0x1234) → next cycle write_en=1, addr 3, data 0x1234; count stays 0.
- Pipe request (FROM_MEMORY, addr 5, mem 0xCAFE) in the same cycle as load return (addr 7, 0xBEEF):
  - next cycle: write r7=0xBEEF.
  - following cycle: write r5=0xCAFE.
  - count goes 1 then 0.
- ld_valid_i held high 6 cycles while pipe sends writing requests every cycle with DEPTH=4:
  - 4 accepted, ready low from the fifth cycle.
  - after ld drops, the 4 entries retire in order with one write per cycle.
  - ready returns high the cycle after the first pop.
- Pipe request with write_en deasserted (addr 9) → accepted and no write; a non-ALU/MEM source with write_en → r-addr written with 0.
- With WB_FORWARD_EN: queue holds r2=0x11 then r2=0x22 → lookup_addr_i=2 gives hit=1, data 0x22; lookup of r4 gives hit=0, data 0. Without WB_FORWARD_EN the same stimulus gives hit=0.
- Assert rst_n_i asynchronously with 3 queued entries → outputs zero immediately, count 0, ready 1; no queued write appears after reset release.
